// File: rtl/process_features_sdiv_48s_32s_32_seq.sv
// Sequential signed divider: 48-bit dividend by 32-bit divisor using restoring
// shift-subtract. Gives a saturated 32-bit quotient, a remainder, and div-by-zero and overflow flags.
module process_features_sdiv_48s_32s_32_seq #(
    parameter int din0_WIDTH = 48,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [dout_WIDTH-1:0] quot,
    output logic [dout_WIDTH-1:0] rem,
    output logic                  div_zero,
    output logic                  ovf
);
    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int WO = dout_WIDTH;
    localparam int CW = $clog2(W0);
    localparam logic [W0-1:0] QPOS_MAX = W0'((64'd1 << (WO - 1)) - 64'd1);
    localparam logic [W0-1:0] QNEG_MAX = W0'(64'd1 << (WO - 1));
    localparam logic [WO-1:0] SAT_POS  = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] SAT_NEG  = {1'b1, {(WO-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W0-1:0]   dvd_q;      // dividend magnitude, shifted out MSB-first, quotient bits shifted in
    logic [W1-1:0]   dvs_q;      // divisor magnitude (2^31 fits unsigned)
    logic [W1-1:0]   acc_q;      // partial remainder, always < divisor magnitude
    logic            sign_n_q;
    logic            sign_d_q;
    logic            zero_q;
    logic [WO-1:0]   quot_q, rem_q;
    logic            div_zero_q, ovf_q;

    logic [W1:0]     shifted, diff;
    logic            take;
    logic [W0-1:0]   qneg;
    logic [W1-1:0]   rneg;
    logic [WO-1:0]   quot_fix, rem_fix;
    logic            ovf_fix;

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (din_valid) state_d = ITER;
            ITER: if (cnt_q == CW'(W0 - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (dout_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only
    always_comb begin
        din_ready  = (state_q == IDLE);
        dout_valid = (state_q == DONE);
    end

    always_comb begin
        shifted = {acc_q, dvd_q[W0-1]};
        diff    = shifted - {1'b0, dvs_q};
        take    = (shifted >= {1'b0, dvs_q});
    end

    // Sign restoration and saturation of the finished magnitudes
    always_comb begin
        qneg     = -dvd_q;
        rneg     = -acc_q;
        quot_fix = dvd_q[WO-1:0];
        ovf_fix  = 1'b0;
        rem_fix  = sign_n_q ? WO'(rneg) : WO'(acc_q);
        if (zero_q) begin
            quot_fix = sign_n_q ? SAT_NEG : SAT_POS;
            rem_fix  = '0;
        end else if (sign_n_q ^ sign_d_q) begin
            if (dvd_q > QNEG_MAX) begin
                quot_fix = SAT_NEG;
                ovf_fix  = 1'b1;
            end else begin
                quot_fix = qneg[WO-1:0];
            end
        end else if (dvd_q > QPOS_MAX) begin
            quot_fix = SAT_POS;
            ovf_fix  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            acc_q      <= '0;
            sign_n_q   <= 1'b0;
            sign_d_q   <= 1'b0;
            zero_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (din_valid) begin
                    dvd_q    <= din0[W0-1] ? -din0 : din0;
                    dvs_q    <= din1[W1-1] ? -din1 : din1;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    sign_n_q <= din0[W0-1];
                    sign_d_q <= din1[W1-1];
                    zero_q   <= (din1 == '0);
                end
                ITER: begin
                    acc_q <= take ? diff[W1-1:0] : shifted[W1-1:0];
                    dvd_q <= {dvd_q[W0-2:0], take};
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    quot_q     <= quot_fix;
                    rem_q      <= rem_fix;
                    div_zero_q <= zero_q;
                    ovf_q      <= ovf_fix;
                end
                default: ;
            endcase
        end
    end

    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = div_zero_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_process_features_sdiv_48s_32s_32_seq.sv
// Randomised scoreboard bench for the sequential 48/32 signed divider, with directed corner cases,
// back-pressure, ignored din_valid pulses and a mid-operation reset.
module tb_process_features_sdiv_48s_32s_32_seq;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        din_valid, din_ready;
    logic [47:0] din0;
    logic [31:0] din1;
    logic        dout_valid, dout_ready;
    logic [31:0] quot, rem;
    logic        div_zero, ovf;

    process_features_sdiv_48s_32s_32_seq dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .din_valid(din_valid), .din_ready(din_ready),
        .din0(din0), .din1(din1),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .quot(quot), .rem(rem), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          acc_cyc;
        logic [47:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   bp_en = 0;
    int   stall_left = 0;
    bit   holding = 0;
    bit   chk_next = 0;
    logic [65:0] held;

    always @(posedge ap_clk) cyc++;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic, then saturation
    function automatic exp_t model(input logic [47:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, qt, rt;
        sa = {{16{a[47]}}, a};
        sb = {{32{b[31]}}, b};
        e.a = a; e.b = b; e.acc_cyc = 0;
        e.dz = 1'b0; e.ov = 1'b0;
        if (sb == 0) begin
            e.dz = 1'b1;
            e.q  = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.r  = 32'h0;
        end else begin
            qt = sa / sb;
            rt = sa % sb;
            if (qt > 64'sd2147483647) begin
                e.q = 32'h7FFF_FFFF; e.ov = 1'b1;
            end else if (qt < -64'sd2147483648) begin
                e.q = 32'h8000_0000; e.ov = 1'b1;
            end else begin
                e.q = qt[31:0];
            end
            e.r = rt[31:0];
        end
        return e;
    endfunction

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic do_op(input logic [47:0] a, input logic [31:0] b, input bit push);
        int   t;
        exp_t e;
        t = 0;
        @(negedge ap_clk);
        while (!din_ready) begin
            t++;
            if (t > 400) begin
                $display("FAIL din_ready_timeout: din_ready stuck at %0b, required 1", din_ready);
                $fatal(1, "din_ready never returned");
            end
            @(negedge ap_clk);
        end
        din0 = a; din1 = b; din_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        din_valid = 1'b0;
        din0 = {$urandom, $urandom};
        din1 = $urandom;
        if (push) begin
            e = model(a, b);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    // Back-pressure driver
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            if (stall_left > 0 && dout_valid) begin
                dout_ready = 1'b0;
                stall_left--;
            end else begin
                dout_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge ap_clk) begin
        if (mon_en) begin
            if (chk_next) begin
                chk_next = 0;
                check("ready_after_handshake", {64'd0, din_ready, dout_valid}, {64'd0, 2'b10});
            end
            if (dout_valid) begin
                if (!holding) begin
                    holding = 1;
                    held = {quot, rem, div_zero, ovf};
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_dout: quot=%h rem=%h with no operation pending", quot, rem);
                    end else begin
                        check("latency", 66'(cyc - exp_q[0].acc_cyc), 66'd49);
                    end
                end else begin
                    check("hold_stable", {quot, rem, div_zero, ovf}, held);
                end
                if (dout_ready) begin
                    if (exp_q.size() != 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("result %h/%h", e.a, e.b),
                              {quot, rem, div_zero, ovf}, {e.q, e.r, e.dz, e.ov});
                    end
                    check("din_ready_low_in_done", {65'd0, din_ready}, 66'd0);
                    holding = 0;
                    chk_next = 1;
                end
            end
        end
    end

    function automatic logic [47:0] rand_dividend();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: return 48'h8000_0000_0000;
            1: return 48'hFFFF_8000_0000;
            2: return {{16{t[31]}}, t[31:0]};
            3: return {{32{t[15]}}, t[15:0]};
            default: return t[47:0];
        endcase
    endfunction

    function automatic logic [31:0] rand_divisor();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(1, 20));
            5: return -32'($urandom_range(1, 20));
            6: return {{16{t[15]}}, t[15:0]};
            default: return t;
        endcase
    endfunction

    initial begin
        int t;
        ap_rst_n = 1'b0; din_valid = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("reset_state", {32'd0, din_ready, dout_valid, quot[15:0], rem[15:0], div_zero, ovf},
              {32'd0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0});
        check("reset_quot_rem", {2'b00, quot, rem}, 66'd0);
        ap_rst_n = 1'b1;
        mon_en = 1;

        do_op(48'd100, 32'd7, 1);
        do_op(-48'sd100, 32'd7, 1);
        do_op(48'h7FFF_FFFF_FFFF, 32'd1, 1);
        do_op(48'hFFFF_8000_0000, 32'hFFFF_FFFF, 1);
        do_op(-48'sd5, 32'd0, 1);
        do_op(48'h8000_0000_0000, 32'h8000_0000, 1);

        // Held result under stall, with ignored din_valid pulses while busy
        stall_left = 10;
        do_op(48'd1000, -32'sd3, 1);
        repeat (5) @(posedge ap_clk);
        #1;
        din_valid = 1'b1; din0 = 48'd7; din1 = 32'd1;
        repeat (5) @(posedge ap_clk);
        #1;
        din_valid = 1'b0;

        // Abort an operation with a one-edge reset partway through
        do_op(48'd12345, 32'd67, 0);
        repeat (20) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("abort_state", {30'd0, din_ready, dout_valid, quot, div_zero, ovf, 2'b00},
              {30'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00});
        check("abort_rem", {34'd0, rem}, 66'd0);
        repeat (60) @(negedge ap_clk);
        do_op(48'd48, -32'sd6, 1);

        bp_en = 1;
        for (int i = 0; i < 800; i++) do_op(rand_dividend(), rand_divisor(), 1);

        t = 0;
        while ((exp_q.size() != 0 || dout_valid) && t < 500) begin
            @(negedge ap_clk);
            t++;
        end
        check("drain_pending", 66'(exp_q.size()), 66'd0);
        finish_run();
    end
endmodule
